lsu_mem_access: RTL and testbench

MEM-stage load/store responder. It consumes the decoder's data-memory controls (DMWe, DMsign, DMwidth) plus the load indication, and drives a single-outstanding valid/ack data bus. It formats byte lanes and strobes for stores, and extracts and extends load data. It stalls the pipeline until the bus completes, flags misaligned or illegal accesses, and times out hung transfers.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_mem_access_if.sv | 23 ++
 rtl/lsu_lane_align.sv | 51 +++++
 rtl/lsu_mem_access.sv | 132 +++++++++++++
 tb/tb_lsu_mem_access.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the MEM-stage load/store responder: width codes,
// response error codes and the access FSM state encoding.
package lsu_pkg;

    typedef enum logic [1:0] {
        DM_BYTE    = 2'b00,
        DM_HALF    = 2'b01,
        DM_WORD    = 2'b10,
        DM_ILLEGAL = 2'b11
    } dm_width_e;

    typedef enum logic [1:0] {
        RESP_OK       = 2'b00,
        RESP_MISALIGN = 2'b01,
        RESP_TIMEOUT  = 2'b10
    } resp_err_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_access_if.sv
// Single-outstanding valid/ack data bus between the LSU (master) and the
// data memory or fabric (slave).
interface lsu_mem_access_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_wstrb;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: store strobes and lane-replicated store
// data, load byte/half extraction with sign/zero extension, and the
// alignment legality check. Purely combinational.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  dm_width_e   width,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] lane_wdata,
    output logic [31:0] ext_rdata,
    output logic        illegal
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Select lanes by width; sign=0 sign-extends, sign=1 zero-extends.
    always_comb begin
        wstrb      = '0;
        lane_wdata = '0;
        ext_rdata  = '0;
        illegal    = 1'b0;
        rbyte      = rdata[{addr_lo, 3'b000} +: 8];
        rhalf      = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (width)
            DM_BYTE: begin
                wstrb      = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
                ext_rdata  = {{24{~sign & rbyte[7]}}, rbyte};
            end
            DM_HALF: begin
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                ext_rdata  = {{16{~sign & rhalf[15]}}, rhalf};
                illegal    = addr_lo[0];
            end
            DM_WORD: begin
                wstrb      = '1;
                lane_wdata = wdata;
                ext_rdata  = rdata;
                illegal    = |addr_lo;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// MEM-stage load/store responder. Accepts one load or store at a time,
// issues it on the valid/ack bus, stalls the pipeline until completion and
// returns a one-cycle response with extended load data or an error code.
module lsu_mem_access
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_we,
    input  logic              mem_sign,
    input  logic [1:0]        mem_width,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    lsu_mem_access_if.master  bus
);

    lsu_state_e        state, state_nxt;
    logic              req;
    logic              illegal;
    logic              align_illegal;
    logic              timeout_hit;
    logic [CNT_W-1:0]  wait_cnt;
    logic [3:0]        lane_wstrb;
    logic [31:0]       lane_wdata;
    logic [31:0]       ext_rdata;

    assign req         = mem_rd | mem_we;
    assign illegal     = align_illegal | (mem_rd & mem_we);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Request inputs are held stable while stalled, so the live address and
    // width also steer load extraction when the ack arrives.
    lsu_lane_align u_lane_align (
        .addr_lo    (mem_addr[1:0]),
        .width      (dm_width_e'(mem_width)),
        .sign       (mem_sign),
        .wdata      (mem_wdata),
        .rdata      (bus.bus_rdata),
        .wstrb      (lane_wstrb),
        .lane_wdata (lane_wdata),
        .ext_rdata  (ext_rdata),
        .illegal    (align_illegal)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state, stall and response-valid decode.
    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = req;
                if (req) state_nxt = illegal ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (bus.bus_ack || timeout_hit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Stall is combinational from the request, so force it low while
        // reset is held to keep every output quiet during reset.
        if (rst) stall = 1'b0;
    end

    // Bus launch, completion capture and timeout counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wstrb <= '0;
            bus.bus_wdata <= '0;
            resp_rdata    <= '0;
            resp_err      <= RESP_OK;
            wait_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (illegal) begin
                            resp_err   <= RESP_MISALIGN;
                            resp_rdata <= '0;
                        end else begin
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= mem_we;
                            bus.bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                            bus.bus_wstrb <= mem_we ? lane_wstrb : 4'b0000;
                            bus.bus_wdata <= mem_we ? lane_wdata : 32'h0;
                            wait_cnt      <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        resp_err    <= RESP_OK;
                        resp_rdata  <= bus.bus_we ? 32'h0 : ext_rdata;
                    end else if (timeout_hit) begin
                        bus.bus_req <= 1'b0;
                        resp_err    <= RESP_TIMEOUT;
                        resp_rdata  <= '0;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench for lsu_mem_access: directed cases followed by random
// loads/stores against a behavioural memory responder with random ack delay.
module tb_lsu_mem_access;
    import lsu_pkg::*;

    localparam int ADDR_W = 32;
    localparam int TO     = 16;
    localparam int NEVER  = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_we, mem_sign;
    logic [1:0]  mem_width;
    logic [31:0] mem_addr, mem_wdata;
    logic        stall, resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    lsu_mem_access_if #(.ADDR_W(ADDR_W)) bus_if ();

    lsu_mem_access #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rd     (mem_rd),
        .mem_we     (mem_we),
        .mem_sign   (mem_sign),
        .mem_width  (mem_width),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .bus        (bus_if.master)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; logic [1:0] err; } resp_t;
    typedef struct { logic we; logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata; } busx_t;

    resp_t       resp_q[$];
    busx_t       bus_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cur_delay = 0;
    logic [31:0] cur_word = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arithmetic on the word, not bit slicing.
    function automatic logic [31:0] model_load(input logic [31:0] word, input int width,
                                               input int a, input logic sgn);
        longint v;
        longint w;
        w = word;
        if (width == 0) begin
            v = (w >> (8 * a)) % 256;
            if (!sgn && v >= 128) v = v - 256;
        end else if (width == 1) begin
            v = (w >> (8 * a)) % 65536;
            if (!sgn && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_strb(input int width, input int a);
        if (width == 0) return 4'(1 << a);
        if (width == 1) return (a >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input int width, input logic [31:0] wd);
        if (width == 0) return (wd % 256) * 32'h01010101;
        if (width == 1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    task automatic idle(input int n);
        mem_rd = 1'b0;
        mem_we = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Issue one access in an IDLE cycle and hold it until resp_valid.
    task automatic do_txn(input logic rd, input logic we, input logic sgn, input int width,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] word, input int delay);
        int    a;
        bit    ill;
        bit    done;
        int    exp_stall;
        int    stall_cnt;
        resp_t r;
        busx_t b;
        a   = int'(addr % 4);
        ill = (width == 3) || (rd && we) || (width == 1 && (a % 2) != 0) || (width == 2 && a != 0);
        if (ill) begin
            r.rdata   = 32'h0;
            r.err     = 2'b01;
            exp_stall = 1;
        end else begin
            b.we    = we;
            b.addr  = addr - 32'(a);
            b.wstrb = we ? model_strb(width, a) : 4'd0;
            b.wdata = we ? model_wdata(width, wd) : 32'h0;
            bus_q.push_back(b);
            if (delay < TO) begin
                r.err     = 2'b00;
                r.rdata   = we ? 32'h0 : model_load(word, width, a, sgn);
                exp_stall = delay + 2;
            end else begin
                r.err     = 2'b10;
                r.rdata   = 32'h0;
                exp_stall = TO + 1;
            end
        end
        resp_q.push_back(r);
        cur_delay = delay;
        cur_word  = word;
        mem_rd    = rd;
        mem_we    = we;
        mem_sign  = sgn;
        mem_width = 2'(width);
        mem_addr  = addr;
        mem_wdata = wd;
        #1;
        stall_cnt = stall ? 1 : 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                done = 1'b1;
                chk("stall_in_done", 32'(stall), 32'd0);
            end else if (stall) begin
                stall_cnt++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL resp_wait: no resp_valid within 40 cycles (addr 0x%08h)", addr);
        end
        chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        mem_rd = 1'b0;
        mem_we = 1'b0;
    endtask

    // Response monitor: every resp_valid must match the oldest expectation.
    resp_t mr;
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: resp_valid with nothing outstanding at %0t", $time);
            end else begin
                mr = resp_q.pop_front();
                chk("resp_rdata", resp_rdata, mr.rdata);
                chk("resp_err", 32'(resp_err), 32'(mr.err));
            end
        end
    end

    // Memory responder: checks the launched transfer and acks after
    // cur_delay WAIT cycles; drives stray acks whenever no request is up.
    int    wcnt = 0;
    logic  prev_req = 1'b0;
    busx_t eb;
    always @(negedge clk) begin
        if (bus_if.bus_req) begin
            if (!prev_req) begin
                wcnt = 0;
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bus: bus_req with no legal access at %0t", $time);
                end else begin
                    eb = bus_q.pop_front();
                    chk("bus_we", 32'(bus_if.bus_we), 32'(eb.we));
                    chk("bus_addr", bus_if.bus_addr, eb.addr);
                    chk("bus_wstrb", 32'(bus_if.bus_wstrb), 32'(eb.wstrb));
                    if (eb.we) chk("bus_wdata", bus_if.bus_wdata, eb.wdata);
                end
            end
            bus_if.bus_ack   = (wcnt == cur_delay);
            bus_if.bus_rdata = (wcnt == cur_delay) ? cur_word : $urandom();
            wcnt++;
        end else begin
            bus_if.bus_ack   = ($urandom_range(0, 1) == 1);
            bus_if.bus_rdata = $urandom();
        end
        prev_req = bus_if.bus_req;
    end

    task automatic reset_mid_wait();
        busx_t b;
        b.we    = 1'b0;
        b.addr  = 32'h500;
        b.wstrb = 4'd0;
        b.wdata = 32'h0;
        bus_q.push_back(b);
        cur_delay = NEVER;
        cur_word  = 32'h0;
        mem_rd    = 1'b1;
        mem_we    = 1'b0;
        mem_width = 2'd2;
        mem_addr  = 32'h500;
        repeat (4) @(negedge clk);
        chk("pre_rst_bus_req", 32'(bus_if.bus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        mem_rd = 1'b0;
        rst    = 1'b0;
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, width, d, delay;
        logic rd, we;
        logic [31:0] addr;

        rst = 1'b1;
        mem_rd = 1'b1;
        mem_we = 1'b0;
        mem_sign = 1'b0;
        mem_width = 2'd2;
        mem_addr = '0;
        mem_wdata = '0;
        bus_if.bus_ack = 1'b0;
        bus_if.bus_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("reset_bus_wstrb", 32'(bus_if.bus_wstrb), 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'd0);
        chk("reset_resp_err", 32'(resp_err), 32'd0);
        mem_rd = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        do_txn(1'b0, 1'b1, 1'b0, 2, 32'h104, 32'hDEADBEEF, 32'h0, 2);        idle(1);
        do_txn(1'b1, 1'b0, 1'b0, 0, 32'h203, 32'h0, 32'h80123456, 0);        idle(1);
        do_txn(1'b1, 1'b0, 1'b1, 0, 32'h203, 32'h0, 32'h80123456, 1);        idle(1);
        do_txn(1'b0, 1'b1, 1'b0, 1, 32'h302, 32'h0000A5C3, 32'h0, 0);        idle(1);
        do_txn(1'b1, 1'b0, 1'b1, 1, 32'h302, 32'h0, 32'hBEEF1234, 3);        idle(1);
        do_txn(1'b1, 1'b0, 1'b0, 2, 32'h101, 32'h0, 32'h0, 0);               idle(1);
        do_txn(1'b1, 1'b0, 1'b0, 3, 32'h100, 32'h0, 32'h0, 0);               idle(1);
        do_txn(1'b1, 1'b1, 1'b0, 2, 32'h108, 32'h0, 32'h0, 0);               idle(1);
        do_txn(1'b1, 1'b0, 1'b0, 2, 32'h400, 32'h0, 32'h12345678, NEVER);    idle(4);
        do_txn(1'b1, 1'b0, 1'b0, 2, 32'h404, 32'h0, 32'hCAFEF00D, TO - 1);   idle(1);
        reset_mid_wait();
        do_txn(1'b0, 1'b1, 1'b0, 0, 32'h7, 32'h000000AB, 32'h0, 1);          idle(1);

        for (int n = 0; n < 150; n++) begin
            width = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            k = int'($urandom_range(0, 19));
            rd = (k == 0) || (k < 10);
            we = (k == 0) || (k >= 10);
            addr = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                if (width == 1) addr[0] = 1'b0;
                if (width == 2) addr[1:0] = 2'b00;
            end
            d = int'($urandom_range(0, 9));
            if (d < 7)       delay = int'($urandom_range(0, 3));
            else if (d == 7) delay = TO - 1;
            else if (d == 8) delay = TO - 2;
            else             delay = NEVER;
            do_txn(rd, we, 1'($urandom_range(0, 1)), width, addr, $urandom(), $urandom(), delay);
            idle(int'($urandom_range(1, 3)));
        end

        idle(5);
        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
